ic7458_pin_tester: RTL and testbench

//  Exhaustive sequential tester that drives the 10 inputs of a 7458-style AND-OR chip.

---
 rtl/ic7458_pkg.sv | 25 ++
 rtl/ic7458_if.sv | 10 +
 rtl/ic7458_ref_model.sv | 11 +
 rtl/ic7458_pin_tester.sv | 144 ++++++++++++++
 tb/tb_ic7458_pin_tester.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ic7458_pkg.sv
// Shared types, constants and golden function for the 7458 AND-OR pin tester.
package ic7458_pkg;

  localparam int NUM_VEC = 1024;
  localparam int VEC_W   = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } tester_state_t;

  // Expected chip outputs for one input vector, returned as {p1y, p2y}.
  // vec[5:0] = p1a..p1f, vec[9:6] = p2a..p2d.
  function automatic logic [1:0] ic7458_golden(input logic [VEC_W-1:0] vec);
    logic p1y;
    logic p2y;
    p1y = (vec[0] & vec[1] & vec[2]) | (vec[3] & vec[4] & vec[5]);
    p2y = (vec[6] & vec[7]) | (vec[8] & vec[9]);
    return {p1y, p2y};
  endfunction

endpackage

// File: rtl/ic7458_if.sv
// Pin bundle between the tester (master drives inputs) and the chip (slave drives outputs).
interface ic7458_if;
  logic [5:0] drv_p1;
  logic [3:0] drv_p2;
  logic       obs_p1y;
  logic       obs_p2y;

  modport master (output drv_p1, output drv_p2, input obs_p1y, input obs_p2y);
  modport slave  (input drv_p1, input drv_p2, output obs_p1y, output obs_p2y);
endinterface

// File: rtl/ic7458_ref_model.sv
// Combinational golden model of the 7458 AND-OR chip, indexed by the flat vector.
module ic7458_ref_model
  import ic7458_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [1:0]       golden
);

  assign golden = ic7458_golden(vec);

endmodule

// File: rtl/ic7458_pin_tester.sv
// Exhaustive sweep tester for a 7458-style AND-OR chip: drives every input
// vector, waits SETTLE_CYCLES, samples both outputs and tallies mismatches.
//
// Control handshake: start is a level sampled only in IDLE or DONE and ignored
// while busy; done is a registered level that rises one cycle after the last
// vector is checked and stays high until the next accepted start or an abort;
// pass/err_count/first_fail_* are valid whenever done is high; abort overrides
// start and every transition, returning to IDLE with results and pins held.
module ic7458_pin_tester
  import ic7458_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
)
(
  input  logic              clk,
  input  logic              areset_n,
  input  logic              start,
  input  logic              abort,
  ic7458_if.master          pins,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [10:0]       err_count,
  output logic [VEC_W-1:0]  first_fail_vec,
  output logic              first_fail_valid,
  output tester_state_t     dbg_state
);

  // Last count value in SETTLE; unused when SETTLE_CYCLES is 0 (SETTLE is skipped).
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  tester_state_t    state;
  tester_state_t    state_next;
  logic [VEC_W-1:0] vec;
  logic [3:0]       settle_cnt;
  logic [5:0]       drv_p1_q;
  logic [3:0]       drv_p2_q;
  logic [1:0]       golden;
  logic             mismatch;
  logic             last_vec;
  logic             settle_done;
  logic             clear_results;
  logic             load_drv;
  logic             do_check;
  logic             hold_done;

  ic7458_ref_model u_ref (
    .vec    (vec),
    .golden (golden)
  );

  assign mismatch    = ({pins.obs_p1y, pins.obs_p2y} != golden);
  assign last_vec    = (vec == VEC_W'(NUM_VEC - 1));
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign hold_done   = (state == DONE) && (state_next == DONE);
  assign pins.drv_p1 = drv_p1_q;
  assign pins.drv_p2 = drv_p2_q;
  assign dbg_state   = state;

  // State register.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state decode and per-state strobes; abort overrides everything.
  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    clear_results = 1'b0;
    load_drv      = 1'b0;
    do_check      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clear_results = 1'b1;
          state_next    = DRIVE;
        end
      end
      DRIVE: begin
        busy       = 1'b1;
        load_drv   = 1'b1;
        state_next = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_done) state_next = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        do_check   = 1'b1;
        state_next = last_vec ? DONE : DRIVE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next    = IDLE;
      clear_results = 1'b0;
      load_drv      = 1'b0;
      do_check      = 1'b0;
    end
  end

  // Vector counter, pin drive, settle timer, error tally and result flags.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      vec              <= '0;
      settle_cnt       <= '0;
      drv_p1_q         <= '0;
      drv_p2_q         <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      done <= hold_done;
      pass <= hold_done && (err_count == 11'd0);
      if (state == SETTLE) settle_cnt <= settle_cnt + 4'd1;
      if (clear_results) begin
        vec              <= '0;
        err_count        <= '0;
        first_fail_vec   <= '0;
        first_fail_valid <= 1'b0;
      end
      if (load_drv) begin
        drv_p1_q   <= vec[5:0];
        drv_p2_q   <= vec[9:6];
        settle_cnt <= '0;
      end
      if (do_check) begin
        if (mismatch) begin
          err_count <= err_count + 11'd1;
          if (!first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
        end
        if (!last_vec) vec <= vec + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_ic7458_pin_tester.sv
// Bench for ic7458_pin_tester: a behavioural chip with selectable stuck outputs
// feeds the obs pins; each sweep pushes its expected {done delay, pass,
// err_count, first_fail_valid, first_fail_vec} into a queue that a monitor
// pops on every rising done.
module tb_ic7458_pin_tester;
  import ic7458_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk      = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (SETTLE_CYCLES=2) ----------------
  logic          start = 1'b0, abort = 1'b0;
  logic          busy, done, pass, ffv;
  logic [10:0]   err_count;
  logic [9:0]    ffvec;
  tester_state_t st;
  ic7458_if      pins ();

  ic7458_pin_tester #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .areset_n(areset_n), .start(start), .abort(abort), .pins(pins),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_vec(ffvec), .first_fail_valid(ffv), .dbg_state(st)
  );

  // ---------------- DUT (SETTLE_CYCLES=0) ----------------
  logic          start0 = 1'b0, abort0 = 1'b0;
  logic          busy0, done0, pass0, ffv0;
  logic [10:0]   err_count0;
  logic [9:0]    ffvec0;
  tester_state_t st0;
  ic7458_if      pins0 ();

  ic7458_pin_tester #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .areset_n(areset_n), .start(start0), .abort(abort0), .pins(pins0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .first_fail_vec(ffvec0), .first_fail_valid(ffv0), .dbg_state(st0)
  );

  // ---------------- chip stand-in ----------------
  // mode 0: good chip, 1: p2y stuck at 0, 2: p1y stuck at 1
  logic [1:0] mode = 2'd0;

  function automatic logic [1:0] chip(input logic [5:0] p1, input logic [3:0] p2);
    return {(&p1[2:0]) | (&p1[5:3]), (&p2[1:0]) | (&p2[3:2])};
  endfunction

  logic [1:0] chip_y, chip0_y;
  assign chip_y        = chip(pins.drv_p1, pins.drv_p2);
  assign chip0_y       = chip(pins0.drv_p1, pins0.drv_p2);
  assign pins.obs_p1y  = (mode == 2'd2) ? 1'b1 : chip_y[1];
  assign pins.obs_p2y  = (mode == 2'd1) ? 1'b0 : chip_y[0];
  assign pins0.obs_p1y = chip0_y[1];
  assign pins0.obs_p2y = chip0_y[0];

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp0_q[$];
  int start_cyc = 0, start0_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [35:0] result(input int delay, input logic p,
                                         input logic [10:0] e, input logic v,
                                         input logic [9:0] f);
    return {13'(delay), p, e, v, f};
  endfunction

  // Monitor: compare each rising done against the oldest expected sweep result.
  logic done_d = 1'b0, done0_d = 1'b0;
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'(exp_q.size()), 64'd1);
      else check("sweep_result",
                 64'(result(cyc - start_cyc, pass, err_count, ffv, ffvec)),
                 64'(exp_q.pop_front()));
    end
    if (done0 && !done0_d) begin
      if (exp0_q.size() == 0) check("unexpected_done0", 64'(exp0_q.size()), 64'd1);
      else check("sweep0_result",
                 64'(result(cyc - start0_cyc, pass0, err_count0, ffv0, ffvec0)),
                 64'(exp0_q.pop_front()));
    end
    done_d  <= done;
    done0_d <= done0;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit mark);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (mark) start_cyc = cyc;
  endtask

  task automatic wait_sweep(input bit which, input int limit);
    for (int i = 0; i < limit && (which ? exp0_q.size() : exp_q.size()) != 0; i++)
      @(negedge clk);
    if (which && exp0_q.size() != 0) begin
      check("sweep0_timeout", 64'(exp0_q.size()), 64'd0);
      exp0_q.delete();
    end
    if (!which && exp_q.size() != 0) begin
      check("sweep_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_vec(input logic [9:0] target);
    int i;
    for (i = 0; i < 5000 && {pins.drv_p2, pins.drv_p1} != target; i++) @(negedge clk);
    if (i == 5000) check("reach_vec", 64'({pins.drv_p2, pins.drv_p1}), 64'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({busy, done, pass, err_count, ffv, ffvec, pins.drv_p2, pins.drv_p1}), 64'd0);
    check("reset_state", 64'(st), 64'(IDLE));
    areset_n = 1'b1;

    // 1: good chip, full sweep, done 4097 edges after start
    mode = 2'd0;
    exp_q.push_back(result(4097, 1'b1, 11'd0, 1'b0, 10'd0));
    pulse_start(1'b1);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_sweep(1'b0, 4200);
    repeat (3) @(negedge clk);
    check("done_held", 64'({done, pass, st == DONE}), 64'b111);

    // 2: p2y stuck at 0
    mode = 2'd1;
    exp_q.push_back(result(4097, 1'b0, 11'd448, 1'b1, 10'h0C0));
    pulse_start(1'b1);
    check("done_clear_on_start", 64'({done, pass}), 64'd0);
    wait_sweep(1'b0, 4200);

    // 3: p1y stuck at 1
    mode = 2'd2;
    exp_q.push_back(result(4097, 1'b0, 11'd784, 1'b1, 10'd0));
    pulse_start(1'b1);
    wait_sweep(1'b0, 4200);

    // abort together with start in DONE: abort wins, results held
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    check("abort_start_state", 64'(st), 64'(IDLE));
    check("abort_start_flags", 64'({busy, done, pass}), 64'd0);
    check("abort_start_err", 64'(err_count), 64'd784);

    // 4: abort at vec 100 with p1y stuck at 1 (81 failures among 0..99)
    pulse_start(1'b0);
    wait_vec(10'd100);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_state", 64'(st), 64'(IDLE));
    check("abort_flags", 64'({busy, done, pass}), 64'd0);
    check("abort_err_held", 64'(err_count), 64'd81);
    check("abort_ff_held", 64'({ffv, ffvec}), 64'({1'b1, 10'd0}));
    check("abort_drv_held", 64'({pins.drv_p2, pins.drv_p1}), 64'd100);
    mode = 2'd0;
    exp_q.push_back(result(4097, 1'b1, 11'd0, 1'b0, 10'd0));
    pulse_start(1'b1);
    check("restart_cleared", 64'({err_count, ffv, ffvec}), 64'd0);
    @(negedge clk);
    check("restart_vec0", 64'({pins.drv_p2, pins.drv_p1}), 64'd0);
    wait_sweep(1'b0, 4200);

    // 5: async reset at vec 500, then a sweep with ignored start pulses
    pulse_start(1'b0);
    wait_vec(10'd500);
    areset_n = 1'b0;
    #1;
    check("midreset_outputs",
          64'({busy, done, pass, err_count, ffv, ffvec, pins.drv_p2, pins.drv_p1}), 64'd0);
    check("midreset_state", 64'(st), 64'(IDLE));
    @(negedge clk) areset_n = 1'b1;
    exp_q.push_back(result(4097, 1'b1, 11'd0, 1'b0, 10'd0));
    pulse_start(1'b1);
    repeat (50) @(negedge clk);
    pulse_start(1'b0);
    repeat (1000) @(negedge clk);
    pulse_start(1'b0);
    wait_sweep(1'b0, 4200);

    // 6: SETTLE_CYCLES=0, vector steps every 2 cycles, done 2049 edges after start
    exp0_q.push_back(result(2049, 1'b1, 11'd0, 1'b0, 10'd0));
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    start0_cyc = cyc;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("drv_step0", 64'({pins0.drv_p2, pins0.drv_p1}), 64'((k - 1) / 2));
    end
    wait_sweep(1'b1, 2200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
